// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the LEGv8 datapath: selects the writeback value, holds it for
// one stage, drives the register-file write port and the EX forwarding bus, and counts retirements.
module mem_wb_stage #(
  parameter int WORD     = 64,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [WORD-1:0]   in_alu_result,
  input  logic [WORD-1:0]   in_read_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [WORD-1:0]   wb_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [WORD-1:0]   fwd_data,
  output logic              retire,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [REG_AW-1:0] ZERO_RD   = REG_AW'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_r;
  logic              reg_write_r;
  logic [REG_AW-1:0] rd_r;
  logic [WORD-1:0]   data_r;
  logic [CNT_W-1:0]  count_r;

  logic [WORD-1:0]   sel_data_s;
  logic              retire_s;
  logic              wr_en_s;

  // Writeback mux sits ahead of the register so wb_data is one cycle behind the memory stage.
  always_comb begin
    sel_data_s = in_alu_result;
    if (in_mem_to_reg) begin
      sel_data_s = in_read_data;
    end else begin
      sel_data_s = in_alu_result;
    end
  end

  // Stage register: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= {REG_AW{1'b0}};
      data_r      <= {WORD{1'b0}};
    end else if (flush) begin
      valid_r     <= 1'b0;
    end else if (!stall) begin
      valid_r     <= in_valid;
      reg_write_r <= in_reg_write;
      rd_r        <= in_rd;
      data_r      <= sel_data_s;
    end
  end

  // Write enable and retire strobe; writes to XZR are dropped but the instruction still retires.
  always_comb begin
    wr_en_s  = 1'b0;
    retire_s = 1'b0;
    if (valid_r && reg_write_r && (rd_r != ZERO_RD)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (valid_r && !stall && !flush) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (retire_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign wb_valid      = valid_r;
  assign wb_reg_write  = wr_en_s;
  assign wb_rd         = rd_r;
  assign wb_data       = data_r;
  assign fwd_valid     = wr_en_s;
  assign fwd_rd        = rd_r;
  assign fwd_data      = data_r;
  assign retire        = retire_s;
  assign retired_count = count_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage: a slot-level model predicts every output each cycle,
// with directed literal checks for the ALU/load/stall/flush/XZR/reset/saturation scenarios.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [63:0] in_alu_result = 64'd0, in_read_data = 64'd0;

  logic        wb_valid, wb_reg_write, fwd_valid, retire;
  logic [4:0]  wb_rd, fwd_rd;
  logic [63:0] wb_data, fwd_data;
  logic [31:0] retired_count;

  logic        s_wb_valid, s_wb_reg_write, s_fwd_valid, s_retire;
  logic [4:0]  s_wb_rd, s_fwd_rd;
  logic [63:0] s_wb_data, s_fwd_data;
  logic [3:0]  s_retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_read_data(in_read_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire), .retired_count(retired_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_read_data(in_read_data),
    .wb_valid(s_wb_valid), .wb_reg_write(s_wb_reg_write), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .retire(s_retire), .retired_count(s_retired_count)
  );

  always #5 clk = ~clk;

  // Model: the instruction sitting in the stage plus how many have left it.
  logic        m_valid, m_rw, m_known;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  longint      m_cnt, m_cnt4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_known <= 1'b1;
      m_rd <= 5'd0; m_data <= 64'd0; m_cnt <= 0; m_cnt4 <= 0;
    end else begin
      if (m_valid && !stall && !flush) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 <= m_cnt4 + 1;
      end
      if (flush) begin
        m_valid <= 1'b0;
        m_known <= 1'b0;
      end else if (!stall) begin
        m_valid <= in_valid;
        m_rw    <= in_reg_write;
        m_rd    <= in_rd;
        m_data  <= in_mem_to_reg ? in_read_data : in_alu_result;
        m_known <= 1'b1;
      end
    end
  end

  // Compare process: inputs change on the falling edge, outputs are checked 2ns later.
  always @(negedge clk) begin
    logic exp_wr;
    #2;
    exp_wr = m_valid && m_rw && (m_rd != 5'd31);
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
    chk("wb_reg_write", {63'd0, wb_reg_write}, {63'd0, exp_wr});
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, exp_wr});
    chk("retire", {63'd0, retire}, {63'd0, (m_valid && !stall && !flush)});
    chk("retired_count", {32'd0, retired_count}, 64'(m_cnt));
    chk("sat_count", {60'd0, s_retired_count}, 64'(m_cnt4));
    if (m_known) begin
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, m_rd});
      chk("wb_data", wb_data, m_data);
      chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, m_rd});
      chk("fwd_data", fwd_data, m_data);
    end
  end

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] rdata,
                       input logic st, input logic fl);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd;
    in_alu_result = alu; in_read_data = rdata; stall = st; flush = fl;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("lit_reset_valid", {63'd0, wb_valid}, 64'd0);
    chk("lit_reset_count", {32'd0, retired_count}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // ALU op then a load behind it
    drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h1234, 64'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h40, 64'hDEADBEEF, 1'b0, 1'b0);
    #3;
    chk("lit_alu_data", wb_data, 64'h1234);
    chk("lit_alu_rd", {59'd0, wb_rd}, 64'd3);
    chk("lit_alu_wr", {63'd0, wb_reg_write}, 64'd1);
    chk("lit_alu_fwd", {63'd0, fwd_valid}, 64'd1);
    chk("lit_alu_retire", {63'd0, retire}, 64'd1);
    chk("lit_alu_cnt0", {32'd0, retired_count}, 64'd0);

    // Load held for three stalled edges
    next_cycle();
    stall = 1'b1;
    #3;
    chk("lit_load_data", wb_data, 64'hDEADBEEF);
    chk("lit_load_cnt", {32'd0, retired_count}, 64'd1);
    chk("lit_stall_retire", {63'd0, retire}, 64'd0);
    next_cycle();
    next_cycle();
    next_cycle();
    #3;
    chk("lit_stall_data", wb_data, 64'hDEADBEEF);
    chk("lit_stall_cnt", {32'd0, retired_count}, 64'd1);

    // Release with an XZR write behind
    drive(1'b1, 1'b1, 1'b0, 5'd31, 64'h5, 64'h0, 1'b0, 1'b0);
    #3;
    chk("lit_release_retire", {63'd0, retire}, 64'd1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 64'h77, 64'h0, 1'b0, 1'b0);
    #3;
    chk("lit_xzr_wr", {63'd0, wb_reg_write}, 64'd0);
    chk("lit_xzr_fwd", {63'd0, fwd_valid}, 64'd0);
    chk("lit_xzr_valid", {63'd0, wb_valid}, 64'd1);
    chk("lit_release_cnt", {32'd0, retired_count}, 64'd2);

    // Flush together with stall
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 64'h99, 64'h0, 1'b1, 1'b1);
    #3;
    chk("lit_xzr_counted", {32'd0, retired_count}, 64'd3);
    chk("lit_flush_retire", {63'd0, retire}, 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    #3;
    chk("lit_flush_valid", {63'd0, wb_valid}, 64'd0);
    chk("lit_flush_cnt", {32'd0, retired_count}, 64'd3);

    // Asynchronous reset between edges with a valid instruction in the stage
    drive(1'b1, 1'b1, 1'b0, 5'd12, 64'hABCD, 64'h0, 1'b0, 1'b0);
    next_cycle();
    #4;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", {63'd0, wb_valid}, 64'd0);
    chk("lit_arst_wr", {63'd0, wb_reg_write}, 64'd0);
    chk("lit_arst_data", wb_data, 64'd0);
    chk("lit_arst_rd", {59'd0, wb_rd}, 64'd0);
    chk("lit_arst_retire", {63'd0, retire}, 64'd0);
    chk("lit_arst_cnt", {32'd0, retired_count}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      next_cycle();
    end

    // Saturation: reset, then 21 edges of back-to-back stores retire 20
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    #4;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'(i), 64'(i), 64'h0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    #3;
    chk("lit_sat_cnt4", {60'd0, s_retired_count}, 64'd15);
    chk("lit_sat_cnt32", {32'd0, retired_count}, 64'd20);
    next_cycle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback-select block for the LEGv8 datapath.
- Sits directly downstream of the memory stage (data memory plus branch-resolve logic).
- Captures the ALU result, load data and control for each instruction, then selects the writeback value.
- Drives the register-file write port, the forwarding bus back to EX, and a retired-instruction counter.

Parameters:
- WORD, 64, datapath width (matches `WORD in definitions.vh)
- REG_AW, 5, register address width
- CNT_W, 32, width of the retired-instruction counter
- ZERO_REG, 31, register index hardwired to zero (XZR); writes to it are suppressed

Ports:
- clk  input  1  single pipeline clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold stage contents this cycle
- flush  input  1  invalidate the stage on the next edge
- in_valid  input  1  upstream slot holds a real instruction
- in_reg_write  input  1  instruction writes the register file
- in_mem_to_reg  input  1  1 = writeback from load data, 0 = from ALU result
- in_rd  input  REG_AW  destination register
- in_alu_result  input  WORD  ALU result / effective address from EX/MEM
- in_read_data  input  WORD  data-memory read_data (valid same cycle as address)
- wb_valid  output  1  stage holds a valid instruction
- wb_reg_write  output  1  register-file write enable
- wb_rd  output  REG_AW  register-file write address
- wb_data  output  WORD  register-file write data
- fwd_valid  output  1  forwarding bus carries a usable value
- fwd_rd  output  REG_AW  forwarding destination
- fwd_data  output  WORD  forwarding value (equals wb_data)
- retire  output  1  one-cycle pulse; instruction leaves stage this edge
- retired_count  output  CNT_W  saturating count of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous): wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, fwd_valid=0, fwd_rd=0, fwd_data=0, retire=0, retired_count=0. Takes effect immediately regardless of clk.
- Reset deassertion mid-stream:
  - First edge after release behaves as a normal capture.
  - No instruction in flight before reset is retired or written.
- Writeback select happens before the register: the captured data is in_mem_to_reg ? in_read_data : in_alu_result. This gives one cycle of latency from memory stage to wb_data.
- Priority on each rising edge, highest first: flush, stall, capture.
  - flush=1: valid<=0; data, rd and ctrl registers may hold any value; flush wins over simultaneous stall.
  - stall=1 (flush=0): all registers hold.
  - Otherwise: valid<=in_valid; rd, ctrl and data captured.
- Output rules:
  - wb_reg_write = valid & captured reg_write & (wb_rd != ZERO_REG). This is combinational from registers and stays asserted while stalled (the repeated write is idempotent).
  - fwd_valid = wb_reg_write. fwd_rd = wb_rd. fwd_data = wb_data.
- Retire rules:
  - retire = wb_valid & ~stall & ~flush, combinational. An instruction retires on the edge where it is replaced.
  - A flushed instruction does not retire.
  - A stalled instruction retires once, on the edge where stall releases.
  - retired_count increments by 1 on each edge where retire=1, and saturates at 2^CNT_W-1 (no wrap).
- Instructions with reg_write=0 (stores, branches) with valid=1 still retire and are counted.
- in_rd = ZERO_REG: the instruction is captured and counted, but produces no write and no forwarding.

Test Plan:
- Reset mid-stream: pull rst_n low asynchronously between edges while wb_valid=1 -> all outputs 0 immediately; retired_count=0.
- ALU op: in_valid=1, reg_write=1, mem_to_reg=0, rd=3, alu_result=0x1234 -> next edge: wb_reg_write=1, wb_rd=3, wb_data=0x1234, fwd_valid=1; retire=1 on the following unstalled edge, count goes to 1.
- Load: mem_to_reg=1, read_data=0xDEADBEEF, alu_result=0x40, rd=7 -> wb_data=0xDEADBEEF.
- Hold behaviour:
  - Stall for 3 edges -> outputs unchanged, retire=0, count unchanged.
  - Release -> retire=1 for exactly one edge, count +1.
- Flush and XZR:
  - flush=1 together with stall=1 -> wb_valid=0 next edge, retire=0 that edge, no count.
  - rd=31 with reg_write=1 -> wb_reg_write=0, fwd_valid=0, still counted.
- Saturation: CNT_W=4 with 20 back-to-back valid stores -> retired_count stops at 15.
